lfsr_stream_decrypt: RTL and testbench

- Receive side of the LFSR stream cipher: turns ciphertext bytes back into plaintext by XORing each one with the matching LFSR keystream byte.
- The keystream generator is the same 8-bit Fibonacci LFSR as the transmit side: same taps, same seed, same shift direction.
- Byte-oriented valid/ready stream in and out, with a one-entry registered output stage.
- Sits between the ciphertext input pins/stream and the downstream plaintext consumer.

---
 rtl/lfsr_stream_decrypt_if.sv | 20 ++
 rtl/lfsr_stream_decrypt.sv | 103 ++++++++++
 tb/tb_lfsr_stream_decrypt.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_stream_decrypt_if.sv
// Ciphertext-in / plaintext-out byte stream pair for the LFSR decryptor.
// The decryptor takes the slave view; the feeding/consuming side takes master.
interface lfsr_stream_decrypt_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/lfsr_stream_decrypt.sv
// Receive-side LFSR stream cipher: XORs each accepted ciphertext byte with the
// current 8-bit Fibonacci LFSR state and presents it through a one-entry output register.
module lfsr_stream_decrypt #(
  parameter logic [7:0] SEED  = 8'h41,
  parameter logic [7:0] TAPS  = 8'hE1,
  parameter int         CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [7:0]           seed_in,
  lfsr_stream_decrypt_if.slave bus,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       lfsr_q;
  logic [7:0]       m_data_q;
  logic             m_valid_q;
  logic [CNT_W-1:0] count_q;
  logic             s_ready_c;
  logic             accept;
  logic             fb;

  assign fb     = ^(lfsr_q & TAPS);
  assign accept = bus.s_valid & s_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // seed_load wins over the normal IDLE/RUN/DRAIN progression
  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = en ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (en) state_d = RUN;
        RUN:     if (!en) state_d = DRAIN;
        DRAIN: begin
          if (en) begin
            state_d = RUN;
          end else if (!m_valid_q || bus.m_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready_c = 1'b0;
    busy      = 1'b0;
    if (state_q == RUN && en && !seed_load) begin
      s_ready_c = !m_valid_q || bus.m_ready;
    end
    if (state_q == RUN || state_q == DRAIN) begin
      busy = 1'b1;
    end
  end

  // The keystream only advances on an accepted byte, so idle gaps never skew it
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= SEED;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      count_q   <= '0;
    end else if (seed_load) begin
      lfsr_q    <= (seed_in == 8'h00) ? SEED : seed_in;
      m_valid_q <= 1'b0;
      count_q   <= '0;
    end else if (accept) begin
      m_data_q  <= bus.s_data ^ lfsr_q;
      m_valid_q <= 1'b1;
      lfsr_q    <= {lfsr_q[6:0], fb};
      count_q   <= count_q + CNT_W'(1);
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign byte_count  = count_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Bench for lfsr_stream_decrypt: directed byte streams checked every cycle against
// a keystream-index model, plus literal expectations for the known keystream bytes.
module tb_lfsr_stream_decrypt;

  logic        clk;
  logic        rst;
  logic        en;
  logic        seed_load;
  logic [7:0]  seed_in;
  logic [15:0] byte_count;
  logic        busy;

  lfsr_stream_decrypt_if bus ();

  lfsr_stream_decrypt #(
    .SEED (8'h41),
    .TAPS (8'hE1),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .bus       (bus),
    .byte_count(byte_count),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: mode 0 idle, 1 running, 2 draining; keystream tracked as (base seed, index)
  int          mMode  = 0;
  logic [7:0]  mBase  = 8'h41;
  int          mIdx   = 0;
  logic [15:0] mCnt   = 16'd0;
  logic        mValid = 1'b0;
  logic [7:0]  mData  = 8'h00;
  logic        modelStarted = 1'b0;
  logic        lastAccept   = 1'b0;
  logic [7:0]  outLog[$];

  logic [7:0]  plain[300];
  logic [7:0]  cipher[300];

  wire expReady = (mMode == 1) && en && !seed_load && (!mValid || bus.m_ready);
  wire modelAcc = !rst && expReady && bus.s_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int stepKey(input int k);
    int fb;
    fb = (((k >> 7) & 1) + ((k >> 6) & 1) + ((k >> 5) & 1) + (k & 1)) % 2;
    return (k * 2 + fb) % 256;
  endfunction

  function automatic logic [7:0] keystreamAt(input logic [7:0] seed, input int n);
    int k;
    k = seed;
    for (int i = 0; i < n; i++) k = stepKey(k);
    return k[7:0];
  endfunction

  function automatic int periodOf(input logic [7:0] seed);
    int k;
    k = seed;
    for (int n = 1; n <= 300; n++) begin
      k = stepKey(k);
      if (k == seed) return n;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  always @(posedge clk) begin
    modelStarted <= 1'b1;
    lastAccept   <= modelAcc;
    if (rst) begin
      mMode  <= 0;
      mBase  <= 8'h41;
      mIdx   <= 0;
      mCnt   <= 16'd0;
      mValid <= 1'b0;
      mData  <= 8'h00;
    end else begin
      if (seed_load) mMode <= en ? 1 : 0;
      else if (mMode == 0 && en) mMode <= 1;
      else if (mMode == 1 && !en) mMode <= 2;
      else if (mMode == 2 && en) mMode <= 1;
      else if (mMode == 2 && (!mValid || bus.m_ready)) mMode <= 0;

      if (seed_load) begin
        mBase  <= (seed_in == 8'h00) ? 8'h41 : seed_in;
        mIdx   <= 0;
        mCnt   <= 16'd0;
        mValid <= 1'b0;
      end else if (modelAcc) begin
        mData  <= bus.s_data ^ keystreamAt(mBase, mIdx);
        mValid <= 1'b1;
        mIdx   <= (mIdx + 1) % 255;
        mCnt   <= mCnt + 16'd1;
      end else if (bus.m_ready) begin
        mValid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelStarted) begin
      checkOutput("m_valid", {31'd0, bus.m_valid}, {31'd0, mValid});
      if (mValid) checkOutput("m_data", {24'd0, bus.m_data}, {24'd0, mData});
      checkOutput("s_ready", {31'd0, bus.s_ready}, {31'd0, expReady});
      checkOutput("byte_count", {16'd0, byte_count}, {16'd0, mCnt});
      checkOutput("busy", {31'd0, busy}, {31'd0, (mMode != 0)});
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) outLog.push_back(bus.m_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Holds s_valid high with byte b until the model sees it taken; leaves s_valid asserted
  task automatic applyStimulus(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (lastAccept) break;
    end
    checkOutput("accept_timeout", {31'd0, lastAccept}, 32'd1);
  endtask

  task automatic pulseSeed(input logic [7:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    tick(1);
    seed_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    int t0;
    rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b0;
    tick(2);
    rst = 1'b0;

    $display("[TB] reset state and model keystream pins");
    checkOutput("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("rst_m_data", {24'd0, bus.m_data}, 32'd0);
    checkOutput("rst_byte_count", {16'd0, byte_count}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("ks0", {24'd0, keystreamAt(8'h41, 0)}, 32'h41);
    checkOutput("ks1", {24'd0, keystreamAt(8'h41, 1)}, 32'h82);
    checkOutput("ks2", {24'd0, keystreamAt(8'h41, 2)}, 32'h05);
    checkOutput("ks3", {24'd0, keystreamAt(8'h41, 3)}, 32'h0B);
    checkOutput("period", periodOf(8'h41), 32'd255);

    $display("[TB] zero ciphertext back-to-back");
    en = 1'b1; bus.m_ready = 1'b1;
    base = outLog.size();
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("zero_count", outLog.size() - base, 32'd4);
    checkOutput("zero_b0", {24'd0, outLog[base]}, 32'h41);
    checkOutput("zero_b1", {24'd0, outLog[base+1]}, 32'h82);
    checkOutput("zero_b2", {24'd0, outLog[base+2]}, 32'h05);
    checkOutput("zero_b3", {24'd0, outLog[base+3]}, 32'h0B);
    checkOutput("zero_byte_count", {16'd0, byte_count}, 32'd4);

    $display("[TB] Hi decrypt");
    doReset();
    base = outLog.size();
    applyStimulus(8'h09);
    applyStimulus(8'hEB);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("hi_H", {24'd0, outLog[base]}, 32'h48);
    checkOutput("hi_i", {24'd0, outLog[base+1]}, 32'h69);

    $display("[TB] backpressure hold");
    doReset();
    bus.m_ready = 1'b0;
    applyStimulus(8'h00);
    bus.s_data = 8'h55;
    tick(3);
    checkOutput("hold_s_ready", {31'd0, bus.s_ready}, 32'd0);
    checkOutput("hold_m_data", {24'd0, bus.m_data}, 32'h41);
    checkOutput("hold_m_valid", {31'd0, bus.m_valid}, 32'd1);
    base = outLog.size();
    bus.m_ready = 1'b1;
    tick(1);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("hold_release0", {24'd0, outLog[base]}, 32'h41);
    checkOutput("hold_release1", {24'd0, outLog[base+1]}, 32'hD7);

    $display("[TB] idle gaps between bytes");
    doReset();
    base = outLog.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00);
      bus.s_valid = 1'b0;
      tick(5);
    end
    checkOutput("gap_b0", {24'd0, outLog[base]}, 32'h41);
    checkOutput("gap_b1", {24'd0, outLog[base+1]}, 32'h82);
    checkOutput("gap_b2", {24'd0, outLog[base+2]}, 32'h05);
    checkOutput("gap_b3", {24'd0, outLog[base+3]}, 32'h0B);

    $display("[TB] seed_load flush and zero-seed substitute");
    bus.m_ready = 1'b0;
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(1);
    pulseSeed(8'h82);
    checkOutput("seed_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("seed_byte_count", {16'd0, byte_count}, 32'd0);
    bus.m_ready = 1'b1;
    base = outLog.size();
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("seed82_first", {24'd0, outLog[base]}, 32'h82);
    pulseSeed(8'h00);
    base = outLog.size();
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("seed00_first", {24'd0, outLog[base]}, 32'h41);

    $display("[TB] drain on en drop");
    doReset();
    base = outLog.size();
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(1);
    bus.m_ready = 1'b0;
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    en = 1'b0;
    tick(1);
    checkOutput("drain_busy", {31'd0, busy}, 32'd1);
    tick(3);
    checkOutput("drain_busy_hold", {31'd0, busy}, 32'd1);
    checkOutput("drain_m_data", {24'd0, bus.m_data}, 32'h82);
    bus.m_ready = 1'b1;
    tick(1);
    checkOutput("drain_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("drain_idle_m_valid", {31'd0, bus.m_valid}, 32'd0);
    en = 1'b1;
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("drain_resume", {24'd0, outLog[base+2]}, 32'h05);
    checkOutput("drain_byte_count", {16'd0, byte_count}, 32'd3);

    $display("[TB] reset mid-stream");
    doReset();
    bus.m_ready = 1'b0;
    applyStimulus(8'h33);
    bus.s_data = 8'h77;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    checkOutput("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("midrst_byte_count", {16'd0, byte_count}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    bus.m_ready = 1'b1;
    base = outLog.size();
    applyStimulus(8'h00);
    bus.s_valid = 1'b0;
    tick(2);
    checkOutput("midrst_first", {24'd0, outLog[base]}, 32'h41);

    $display("[TB] 300-byte block round trip");
    for (int i = 0; i < 300; i++) begin
      plain[i]  = 8'($urandom_range(0, 255));
      cipher[i] = plain[i] ^ keystreamAt(8'h41, i % 255);
    end
    doReset();
    base = outLog.size();
    t0 = cycle;
    for (int i = 0; i < 300; i++) applyStimulus(cipher[i]);
    checkOutput("block_throughput", ((cycle - t0) <= 302) ? 32'd1 : 32'd0, 32'd1);
    bus.s_valid = 1'b0;
    tick(3);
    checkOutput("block_count", outLog.size() - base, 32'd300);
    for (int i = 0; i < 300; i++)
      checkOutput("block_plain", {24'd0, outLog[base+i]}, {24'd0, plain[i]});
    for (int i = 0; i < 45; i++)
      checkOutput("block_period", {24'd0, outLog[base+255+i] ^ cipher[255+i]}, {24'd0, keystreamAt(8'h41, i)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
